// File: rtl/rtc_sched_pkg.sv
// Shared encodings for the PCF8563 transaction scheduler: master command codes,
// FSM states and the step indices of the poll and set-time sequences.
package rtc_sched_pkg;

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_WR      = 3'd1;
    localparam logic [2:0] CMD_RD_ACK  = 3'd2;
    localparam logic [2:0] CMD_RD_NACK = 3'd3;
    localparam logic [2:0] CMD_STOP    = 3'd4;

    localparam logic [7:0] REG_SECONDS = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam logic [2:0] STEP_DEV_WR  = 3'd1;
    localparam logic [2:0] STEP_REG     = 3'd2;
    localparam logic [2:0] STEP_SET_SEC = 3'd3;
    localparam logic [2:0] STEP_DEV_RD  = 3'd4;
    localparam logic [2:0] STEP_SET_MIN = 3'd4;
    localparam logic [2:0] POLL_RD_ACK  = 3'd5;
    localparam logic [2:0] POLL_RD_NACK = 3'd6;
    localparam logic [2:0] POLL_LAST    = 3'd7;
    localparam logic [2:0] SET_LAST     = 3'd5;

    // The last step of either sequence is STOP, so a NACK abort jumps straight to it.
    function automatic logic [2:0] step_cmd(input logic is_set, input logic [2:0] step);
        logic [2:0] cmd;
        cmd = CMD_WR;
        if (is_set) begin
            if (step == 3'd0)          cmd = CMD_START;
            else if (step == SET_LAST) cmd = CMD_STOP;
        end else begin
            case (step)
                3'd0, 3'd3:   cmd = CMD_START;
                POLL_RD_ACK:  cmd = CMD_RD_ACK;
                POLL_RD_NACK: cmd = CMD_RD_NACK;
                POLL_LAST:    cmd = CMD_STOP;
                default:      cmd = CMD_WR;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Purpose: divides sysclk down to a one-cycle poll tick every CLK_HZ/POLL_HZ cycles.
// Latency: first tick a full period after reset release; no backpressure (free running).
module rtc_poll_timer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned POLL_HZ = 10
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PERIOD = CLK_HZ / POLL_HZ;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge sysclk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_i2c_scheduler.sv
// Purpose: serialises periodic time reads and set-time writes onto one byte-level I2C master
// (set path only with RTC_SET_EN). Latency: IDLE->m_valid 1 cycle, m_done->next m_valid 1 cycle.
// Backpressure: m_valid/m_cmd/m_wdata held until m_ready; one command outstanding at a time.
module rtc_i2c_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned POLL_HZ  = 10,
    parameter logic [6:0]  DEV_ADDR = 7'h51
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       set_req,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_ack,
    output logic       m_valid,
    output logic [2:0] m_cmd,
    output logic [7:0] m_wdata,
    input  logic       m_ready,
    input  logic       m_done,
    input  logic [7:0] m_rdata,
    input  logic       m_nack,
    output logic [7:0] reg_led_minute,
    output logic [7:0] reg_led_second,
    output logic       time_valid,
    output logic       err,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic       is_set_q, is_set_d;
    logic       abort_q, abort_d;
    logic       poll_pend_q, poll_pend_d;
    logic [7:0] set_min_q, set_min_d, set_sec_q, set_sec_d;
    logic [7:0] sec_raw_q, sec_raw_d;
    logic [6:0] min_raw_q, min_raw_d;
    logic [6:0] led_sec_q, led_sec_d, led_min_q, led_min_d;
    logic       time_valid_q, time_valid_d;
    logic       err_q, err_d;
    logic       set_ack_q, set_ack_d;

    logic       poll_tick;
    logic       start_set;
    logic [2:0] last_step;
    logic [2:0] cur_cmd;
    logic [7:0] cur_wdata;

    rtc_poll_timer #(
        .CLK_HZ  (CLK_HZ),
        .POLL_HZ (POLL_HZ)
    ) u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (poll_tick)
    );

`ifdef RTC_SET_EN
    assign start_set = set_req;
`else
    logic unused_set_in;
    assign start_set     = 1'b0;
    assign unused_set_in = ^{set_req, set_min, set_sec};
`endif

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        is_set_d     = is_set_q;
        abort_d      = abort_q;
        poll_pend_d  = poll_pend_q | poll_tick;
        set_min_d    = set_min_q;
        set_sec_d    = set_sec_q;
        sec_raw_d    = sec_raw_q;
        min_raw_d    = min_raw_q;
        led_sec_d    = led_sec_q;
        led_min_d    = led_min_q;
        time_valid_d = time_valid_q;
        err_d        = err_q;
        set_ack_d    = 1'b0;
        m_valid      = 1'b0;
        m_cmd        = CMD_START;
        m_wdata      = 8'h00;

        last_step = is_set_q ? SET_LAST : POLL_LAST;
        cur_cmd   = step_cmd(is_set_q, step_q);
        case (step_q)
            STEP_DEV_WR:  cur_wdata = {DEV_ADDR, 1'b0};
            STEP_REG:     cur_wdata = REG_SECONDS;
            STEP_SET_SEC: cur_wdata = is_set_q ? set_sec_q : 8'h00;
            STEP_DEV_RD:  cur_wdata = is_set_q ? set_min_q : {DEV_ADDR, 1'b1};
            default:      cur_wdata = 8'h00;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (start_set) begin
                    state_d   = ST_ISSUE;
                    step_d    = 3'd0;
                    is_set_d  = 1'b1;
                    abort_d   = 1'b0;
                    set_min_d = set_min;
                    set_sec_d = set_sec;
                end else if (poll_pend_q) begin
                    state_d     = ST_ISSUE;
                    step_d      = 3'd0;
                    is_set_d    = 1'b0;
                    abort_d     = 1'b0;
                    poll_pend_d = poll_tick;
                end
            end
            ST_ISSUE: begin
                m_valid = 1'b1;
                m_cmd   = cur_cmd;
                m_wdata = cur_wdata;
                if (m_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    if (cur_cmd == CMD_RD_ACK)  sec_raw_d = m_rdata;
                    if (cur_cmd == CMD_RD_NACK) min_raw_d = m_rdata[6:0];
                    if (step_q == last_step) begin
                        state_d   = ST_IDLE;
                        err_d     = abort_q;
                        set_ack_d = is_set_q;
                        // Display only moves on a complete, un-aborted read.
                        if (!is_set_q && !abort_q) begin
                            led_sec_d    = sec_raw_q[6:0];
                            led_min_d    = min_raw_q;
                            time_valid_d = ~sec_raw_q[7];
                        end
                    end else begin
                        state_d = ST_ISSUE;
                        if (cur_cmd == CMD_WR && m_nack) begin
                            step_d  = last_step;
                            abort_d = 1'b1;
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            step_q       <= 3'd0;
            is_set_q     <= 1'b0;
            abort_q      <= 1'b0;
            poll_pend_q  <= 1'b0;
            set_min_q    <= 8'h00;
            set_sec_q    <= 8'h00;
            sec_raw_q    <= 8'h00;
            min_raw_q    <= 7'h00;
            led_sec_q    <= 7'h00;
            led_min_q    <= 7'h00;
            time_valid_q <= 1'b0;
            err_q        <= 1'b0;
            set_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            is_set_q     <= is_set_d;
            abort_q      <= abort_d;
            poll_pend_q  <= poll_pend_d;
            set_min_q    <= set_min_d;
            set_sec_q    <= set_sec_d;
            sec_raw_q    <= sec_raw_d;
            min_raw_q    <= min_raw_d;
            led_sec_q    <= led_sec_d;
            led_min_q    <= led_min_d;
            time_valid_q <= time_valid_d;
            err_q        <= err_d;
            set_ack_q    <= set_ack_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign set_ack        = set_ack_q;
    assign reg_led_second = {1'b0, led_sec_q};
    assign reg_led_minute = {1'b0, led_min_q};
    assign time_valid     = time_valid_q;
    assign err            = err_q;

endmodule

// File: tb/tb_rtc_i2c_scheduler.sv
// Directed bench for rtc_i2c_scheduler: a byte-level master model checks the command stream
// against a scoreboard of expected commands; display, err and set_ack are checked after each job.
module tb_rtc_i2c_scheduler;
    import rtc_sched_pkg::*;

    logic       sysclk, reset, set_req;
    logic [7:0] set_min, set_sec;
    logic       set_ack, m_valid;
    logic [2:0] m_cmd;
    logic [7:0] m_wdata;
    logic       m_ready, m_done;
    logic [7:0] m_rdata;
    logic       m_nack;
    logic [7:0] reg_led_minute, reg_led_second;
    logic       time_valid, err, busy;

    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    logic [10:0] sb[$];
    int          lat = 1;
    int          stall = 0;
    logic [7:0]  sec_resp = 8'h00;
    logic [7:0]  min_resp = 8'h00;
    logic [7:0]  nack_byte = 8'h00;
    logic        nack_arm = 1'b0;

    rtc_i2c_scheduler #(
        .CLK_HZ   (1000),
        .POLL_HZ  (10),
        .DEV_ADDR (7'h51)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .set_req        (set_req),
        .set_min        (set_min),
        .set_sec        (set_sec),
        .set_ack        (set_ack),
        .m_valid        (m_valid),
        .m_cmd          (m_cmd),
        .m_wdata        (m_wdata),
        .m_ready        (m_ready),
        .m_done         (m_done),
        .m_rdata        (m_rdata),
        .m_nack         (m_nack),
        .reg_led_minute (reg_led_minute),
        .reg_led_second (reg_led_second),
        .time_valid     (time_valid),
        .err            (err),
        .busy           (busy)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] cmd, input logic [7:0] wd);
        sb.push_back({cmd, wd});
    endtask

    task automatic push_poll();
        push_cmd(CMD_START, 8'h00);
        push_cmd(CMD_WR, 8'hA2);
        push_cmd(CMD_WR, 8'h02);
        push_cmd(CMD_START, 8'h00);
        push_cmd(CMD_WR, 8'hA3);
        push_cmd(CMD_RD_ACK, 8'h00);
        push_cmd(CMD_RD_NACK, 8'h00);
        push_cmd(CMD_STOP, 8'h00);
    endtask

    task automatic push_set(input logic [7:0] sec, input logic [7:0] mn);
        push_cmd(CMD_START, 8'h00);
        push_cmd(CMD_WR, 8'hA2);
        push_cmd(CMD_WR, 8'h02);
        push_cmd(CMD_WR, sec);
        push_cmd(CMD_WR, mn);
        push_cmd(CMD_STOP, 8'h00);
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge sysclk);
            n++;
        end
        check(tag, 32'(busy), 32'(lvl));
    endtask

    // Master model: accepts at most one command, answers after lat idle cycles.
    initial begin : master
        bit          pending;
        int          wcnt;
        logic [7:0]  r;
        logic        nk;
        logic [10:0] got_e, exp_e;
        pending = 0; wcnt = 0; r = 8'h00; nk = 1'b0;
        m_ready = 1'b1; m_done = 1'b0; m_rdata = 8'h00; m_nack = 1'b0;
        forever begin
            @(negedge sysclk);
            m_done = 1'b0;
            m_nack = 1'b0;
            if (pending) begin
                if (wcnt == 0) begin
                    m_done  = 1'b1;
                    m_rdata = r;
                    m_nack  = nk;
                    pending = 0;
                end else begin
                    wcnt--;
                end
            end else if (m_valid === 1'b1) begin
                if (stall > 0) begin
                    m_ready = 1'b0;
                    stall--;
                end else begin
                    m_ready = 1'b1;
                    got_e = {m_cmd, (m_cmd == CMD_WR) ? m_wdata : 8'h00};
                    total++;
                    assert (sb.size() != 0) else begin
                        bad++;
                        $error("FAIL cmd_unexpected: observed=%0h expected=none", got_e);
                    end
                    if (sb.size() != 0) begin
                        exp_e = sb.pop_front();
                        check("cmd_stream", 32'(got_e), 32'(exp_e));
                    end
                    pending = 1;
                    wcnt = lat;
                    nk = 1'b0;
                    r = 8'h00;
                    if (m_cmd == CMD_RD_ACK) r = sec_resp;
                    else if (m_cmd == CMD_RD_NACK) r = min_resp;
                    else if (m_cmd == CMD_WR && nack_arm && m_wdata == nack_byte) begin
                        nk = 1'b1;
                        nack_arm = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (set_ack === 1'b1) ack_cnt++;
        end
    end

    initial begin
        int n;
        reset = 1'b0; set_req = 1'b0; set_min = 8'h00; set_sec = 8'h00;
        repeat (4) @(negedge sysclk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_cmd", 32'(m_cmd), 0);
        check("rst_m_wdata", 32'(m_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_time_valid", 32'(time_valid), 0);
        check("rst_led_sec", 32'(reg_led_second), 0);
        check("rst_led_min", 32'(reg_led_minute), 0);
        check("rst_set_ack", 32'(set_ack), 0);
        reset = 1'b1;

        // Plain poll, with the master stalling m_ready on the first command
        sec_resp = 8'h45; min_resp = 8'h12; stall = 2;
        push_poll();
        wait_busy(1'b1, 250, "poll1_start");
        wait_busy(1'b0, 250, "poll1_end");
        check("poll1_sec", 32'(reg_led_second), 32'h45);
        check("poll1_min", 32'(reg_led_minute), 32'h12);
        check("poll1_tv", 32'(time_valid), 1);
        check("poll1_err", 32'(err), 0);
        check("poll1_sb_empty", 32'(sb.size()), 0);

        // VL bit set in the seconds byte
        sec_resp = 8'hC5;
        push_poll();
        wait_busy(1'b1, 250, "poll2_start");
        wait_busy(1'b0, 250, "poll2_end");
        check("vl_sec", 32'(reg_led_second), 32'h45);
        check("vl_tv", 32'(time_valid), 0);

        // NACK on the device address: straight to STOP, display frozen
        sec_resp = 8'h33; min_resp = 8'h07; nack_byte = 8'hA2; nack_arm = 1'b1;
        push_cmd(CMD_START, 8'h00);
        push_cmd(CMD_WR, 8'hA2);
        push_cmd(CMD_STOP, 8'h00);
        wait_busy(1'b1, 250, "nack_start");
        wait_busy(1'b0, 250, "nack_end");
        check("nack_err", 32'(err), 1);
        check("nack_sec", 32'(reg_led_second), 32'h45);
        check("nack_min", 32'(reg_led_minute), 32'h12);
        check("nack_sb_empty", 32'(sb.size()), 0);
        push_poll();
        wait_busy(1'b1, 250, "clean_start");
        wait_busy(1'b0, 250, "clean_end");
        check("clean_err", 32'(err), 0);
        check("clean_sec", 32'(reg_led_second), 32'h33);
        check("clean_min", 32'(reg_led_minute), 32'h07);
        check("clean_tv", 32'(time_valid), 1);

`ifdef RTC_SET_EN
        // Set-time write between polls
        push_set(8'h00, 8'h30);
        set_min = 8'h30; set_sec = 8'h00; set_req = 1'b1;
        wait_busy(1'b1, 5, "set_start");
        set_req = 1'b0; set_min = 8'hFF; set_sec = 8'hFF;
        wait_busy(1'b0, 100, "set_end");
        @(negedge sysclk);
        check("set_ack_once", 32'(ack_cnt), 1);
        check("set_ack_pulse", 32'(set_ack), 0);
        check("set_busy", 32'(busy), 0);
        check("set_sb_empty", 32'(sb.size()), 0);
        check("set_led_keep", 32'(reg_led_second), 32'h33);

        // Tick and set_req pending during a long poll: set first, then exactly one poll
        lat = 14; sec_resp = 8'h59; min_resp = 8'h58;
        push_poll();
        push_set(8'h09, 8'h21);
        push_poll();
        wait_busy(1'b1, 250, "prio_p1_start");
        repeat (10) @(negedge sysclk);
        set_min = 8'h21; set_sec = 8'h09; set_req = 1'b1;
        wait_busy(1'b0, 250, "prio_p1_end");
        @(negedge sysclk);
        check("prio_set_started", 32'(busy), 1);
        set_req = 1'b0;
        n = 0;
        while (set_ack !== 1'b1 && n < 300) begin
            @(negedge sysclk);
            n++;
        end
        check("prio_set_ack", 32'(set_ack), 1);
        lat = 1;
        wait_busy(1'b1, 5, "prio_p2_start");
        wait_busy(1'b0, 100, "prio_p2_end");
        repeat (20) @(negedge sysclk);
        check("prio_single_poll", 32'(busy), 0);
        check("prio_sb_empty", 32'(sb.size()), 0);
        check("prio_ack_cnt", 32'(ack_cnt), 2);
        check("prio_sec", 32'(reg_led_second), 32'h59);
        check("prio_min", 32'(reg_led_minute), 32'h58);
`else
        // Without the set path, set_req must be ignored entirely
        set_min = 8'h30; set_sec = 8'h00; set_req = 1'b1;
        repeat (20) @(negedge sysclk);
        check("noset_busy", 32'(busy), 0);
        check("noset_ack", 32'(ack_cnt), 0);
        set_req = 1'b0;
`endif

        // Reset while waiting on m_done, then a full tick period before the next poll
        lat = 5; sec_resp = 8'h11; min_resp = 8'h22;
        push_poll();
        wait_busy(1'b1, 250, "rstw_start");
        @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        check("rstw_m_valid", 32'(m_valid), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_led_sec", 32'(reg_led_second), 0);
        check("rstw_led_min", 32'(reg_led_minute), 0);
        check("rstw_tv", 32'(time_valid), 0);
        check("rstw_err", 32'(err), 0);
        sb.delete();
        push_poll();
        lat = 1;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        check("post_rst_delay", 32'(n), 101);
        wait_busy(1'b0, 100, "post_rst_end");
        check("post_rst_sec", 32'(reg_led_second), 32'h11);
        check("post_rst_min", 32'(reg_led_minute), 32'h22);
        check("post_rst_tv", 32'(time_valid), 1);
        check("post_rst_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_i2c_scheduler.md
# rtc_i2c_scheduler

Transaction scheduler that owns the byte-level I2C master feeding the PCF8563 RTC. It periodically reads the seconds/minutes registers and services a set-time write request, serialising both onto the single shared master. It presents BCD minute/second bytes to the 7-segment display driver.

## Interface
- CLK_HZ, 50_000_000: sysclk frequency.
- POLL_HZ, 10: time-register read rate.
- DEV_ADDR, 7'h51: PCF8563 7-bit address, giving 8'hA2 for write and 8'hA3 for read.

Ports:
- sysclk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- set_req  in  1  level request to write set_min/set_sec.
- set_min  in  8  BCD minutes to write; sampled when the write is accepted.
- set_sec  in  8  BCD seconds to write; sampled when the write is accepted.
- set_ack  out  1  one-cycle pulse when the write transaction ends.
- m_valid  out  1  command valid to the I2C master.
- m_cmd  out  3  command code (package encoding).
- m_wdata  out  8  write byte for CMD_WR.
- m_ready  in  1  master accepts the command.
- m_done  in  1  one-cycle pulse: the accepted command has finished.
- m_rdata  in  8  read byte; valid with m_done.
- m_nack  in  1  slave NACKed a CMD_WR; valid with m_done.
- reg_led_minute  out  8  BCD minutes, bit7 masked to 0.
- reg_led_second  out  8  BCD seconds, bit7 masked to 0.
- time_valid  out  1  0 if the last read had the VL bit (sec bit7) set.
- err  out  1  last transaction aborted on NACK.
- busy  out  1  a transaction is in progress.

## Operation
- Poll sequence (8 steps):
  - START
  - WR A2
  - WR 02
  - START (repeated start)
  - WR A3
  - RD_ACK, giving seconds
  - RD_NACK, giving minutes
  - STOP
- Set sequence (6 steps):
  - START
  - WR A2
  - WR 02
  - WR set_sec
  - WR set_min
  - STOP
- State machine, with a 3-bit step index:
  - IDLE: when a job is pending, go to ISSUE.
  - ISSUE: hold m_valid with m_cmd/m_wdata stable until m_valid&&m_ready, then go to WAIT.
  - WAIT: on m_done, either advance the step and return to ISSUE, or go to IDLE when the last step completes.
- Exactly one command is outstanding at a time.
- Arbitration at IDLE only; a running transaction is never pre-empted.
  - A pending set request beats a pending poll.
  - Poll and set jobs alternate only in the sense that the poll stays pending while the set runs.
- Poll tick: a counter over CLK_HZ/POLL_HZ cycles sets the pending poll flag. The flag is one deep; ticks arriving while it is already set are dropped.
- Set request:
  - set_req is sampled at IDLE.
  - set_min/set_sec are captured into internal registers on that cycle.
  - set_ack pulses in the cycle the sequence returns to IDLE.
  - set_req must drop before the next IDLE, or it starts another write.
- Read results:
  - The seconds byte is captured on the RD_ACK m_done; bit7 of that byte is latched as the VL flag.
  - The minutes byte is captured on the RD_NACK m_done.
  - reg_led_second and reg_led_minute update together at the STOP m_done, with bit7 cleared. time_valid = ~VL updates at the same time.
- NACK on any WR step:
  - Skip the remaining steps, issue STOP, then return to IDLE.
  - Set err to 1; display registers are unchanged.
  - A set transaction still pulses set_ack.
  - err clears to 0 at the end of the next successful transaction.
- m_done outside WAIT is ignored.

## Timing
- Reset values: every output is 0; state IDLE; poll counter 0; pending flags 0.
- Reset mid-transaction: m_valid is 0 from the next edge and no STOP is issued. The master's own reset handles bus recovery.
- IDLE to m_valid: 1 cycle, registered.
- m_done to the next m_valid: 1 cycle.
- Display outputs change exactly one cycle after the STOP m_done.
- A tick and the end of a transaction in the same cycle: the tick is kept pending.

## Configuration
- RTC_SET_EN
  - Defined: set path compiled in, as described above.
  - Undefined: set_req/set_min/set_sec are ignored, set_ack is tied 0, and only poll transactions exist.

## Structure
- Package rtc_sched_pkg holds:
  - Command encodings: CMD_START=0, CMD_WR=1, CMD_RD_ACK=2, CMD_RD_NACK=3, CMD_STOP=4.
  - REG_SECONDS=8'h02.
  - State typedef.
  - Sequence step constants.
- Sub-module rtc_poll_timer: parameterised tick divider emitting a 1-cycle pulse every CLK_HZ/POLL_HZ cycles.

## Test plan
- Poll with the master model returning 8'h45 then 8'h12 → the m_cmd stream is START, WR A2, WR 02, START, WR A3, RD_ACK, RD_NACK, STOP; reg_led_second=8'h45, reg_led_minute=8'h12, time_valid=1.
- Seconds byte returned as 8'hC5 → reg_led_second=8'h45, time_valid=0.
- set_req with set_min=8'h30, set_sec=8'h00 → WR bytes A2, 02, 00, 30, then STOP; set_ack pulses once; busy drops.
- Model NACKs WR A2 during a poll → STOP is the next command; err=1; display registers unchanged. The next clean poll clears err.
- Poll tick and set_req raised together while busy → the set runs first, then the poll. A second tick arriving during the set yields only one poll.
- reset asserted during WAIT → the next cycle has m_valid=0 and all outputs 0; after release the first poll starts only after a full tick period.
